// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios input PIO: register map and edge modes.
// Also holds the per-bit edge event helper used by the top level.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic [31:0] edge_event(
    input int          mode,
    input logic [31:0] d,
    input logic [31:0] dp
  );
    logic [31:0] ev;
    ev = d ^ dp;
    case (mode)
      EDGE_RISE: ev = d & ~dp;
      EDGE_FALL: ev = ~d & dp;
      default:   ev = d ^ dp;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/nios_pio_in_filter.sv
// Input conditioning: flop synchroniser, then an optional tick-sampled
// two-sample debounce. Output o_d is the filtered input value.
module nios_pio_in_filter #(
  parameter int WIDTH        = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_d
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  if (DEBOUNCE_DIV == 0) begin : g_bypass

    assign o_d = w_s;

  end else begin : g_filt

    localparam int CW =
      (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_DIV - 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_samp;
    logic [WIDTH-1:0] r_d;
    logic             w_tick;
    logic [WIDTH-1:0] w_same;

    assign w_tick = (r_cnt == LAST);
    assign w_same = ~(w_s ^ r_samp);

    // a bit follows the input only once two ticks agree on it
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt  <= '0;
        r_samp <= '0;
        r_d    <= '0;
      end else begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick) begin
          r_samp <= w_s;
          r_d    <= (r_d & ~w_same) | (w_s & w_same);
        end
      end
    end

    assign o_d = r_d;

  end

endmodule

// File: rtl/nios_pio_in_irq.sv
// Avalon-MM input PIO: data, irqmask and W1C edgecapture registers,
// with a level interrupt raised by any unmasked captured edge.
module nios_pio_in_irq
  import nios_pio_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 0,
  parameter int EDGE_TYPE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] r_d_prev;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd;
  logic             w_wr;
  logic             w_unused;

  nios_pio_in_filter #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_DIV (DEBOUNCE_DIV)
  ) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_in    (in_port),
    .o_d     (w_d)
  );

  assign w_unused = ^writedata;
  assign w_wr     = chipselect & ~write_n;
  assign w_ev     = WIDTH'(edge_event(EDGE_TYPE,
                                      32'(w_d),
                                      32'(r_d_prev)));
  assign w_clr    = (w_wr && address == ADDR_EDGE)
                    ? writedata[WIDTH-1:0] : '0;

  // the OR after the clear lets a same-cycle event beat the W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d_prev <= '0;
      r_edge   <= '0;
      r_mask   <= '0;
    end else begin
      r_d_prev <= w_d;
      r_edge   <= (r_edge & ~w_clr) | w_ev;
      if (w_wr && address == ADDR_MASK) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      (address == ADDR_DATA): w_rd = 32'(w_d);
      (address == ADDR_RSVD): w_rd = '0;
      (address == ADDR_MASK): w_rd = 32'(r_mask);
      (address == ADDR_EDGE): w_rd = 32'(r_edge);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd;
    end
  end

  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_nios_pio_in_irq.sv
// Randomised bench for nios_pio_in_irq across four configurations,
// checked every cycle against a history-based reference model.
module tb_nios_pio_in_irq;

  localparam int N    = 4;
  localparam int HMAX = 4096;
  localparam int W  [N] = '{10, 10, 4, 8};
  localparam int SY [N] = '{2, 2, 3, 2};
  localparam int DV [N] = '{0, 4, 0, 3};
  localparam int ET [N] = '{0, 0, 2, 1};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] pin [N];
  logic [31:0] rd  [N];
  logic        irq [N];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_pio_in_irq #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_DIV(0), .EDGE_TYPE(0)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[0]),
    .in_port(pin[0][9:0]), .irq(irq[0])
  );

  nios_pio_in_irq #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_DIV(4), .EDGE_TYPE(0)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[1]),
    .in_port(pin[1][9:0]), .irq(irq[1])
  );

  nios_pio_in_irq #(
    .WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_DIV(0), .EDGE_TYPE(2)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[2]),
    .in_port(pin[2][3:0]), .irq(irq[2])
  );

  nios_pio_in_irq #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_DIV(3), .EDGE_TYPE(1)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[3]),
    .in_port(pin[3][7:0]), .irq(irq[3])
  );

  // reference model: hist[i][k] is the input seen at edge k after reset
  logic [31:0] hist [N][HMAX];
  logic [31:0] m_d   [N];
  logic [31:0] m_dp  [N];
  logic [31:0] m_smp [N];
  logic [31:0] m_ec  [N];
  logic [31:0] m_msk [N];
  logic [31:0] m_rd  [N];
  int k = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int i);
    return (W[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << W[i]) - 32'd1);
  endfunction

  // synchroniser output after edge j: input from SY-1 edges earlier
  function automatic logic [31:0] s_at(input int i, input int j);
    int idx;
    idx = j - SY[i] + 1;
    if (idx < 1 || idx >= HMAX) return 32'd0;
    return hist[i][idx];
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < N; i++) begin
      m_d[i] = 0; m_dp[i] = 0; m_smp[i] = 0;
      m_ec[i] = 0; m_msk[i] = 0; m_rd[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] dn, smp, eq, ev, clr, rdv, wm;
    logic        wr;
    k++;
    wr = chipselect && !write_n;
    for (int i = 0; i < N; i++) begin
      wm = wmask(i);
      if (k < HMAX) hist[i][k] = pin[i] & wm;
      if (DV[i] == 0) begin
        dn = s_at(i, k);
      end else begin
        dn = m_d[i];
        if (k % DV[i] == 0) begin
          smp = s_at(i, k - 1);
          eq  = ~(smp ^ m_smp[i]);
          dn  = (m_d[i] & ~eq) | (smp & eq);
          m_smp[i] = smp;
        end
      end
      case (ET[i])
        0:       ev = m_d[i] & ~m_dp[i];
        1:       ev = ~m_d[i] & m_dp[i];
        default: ev = m_d[i] ^ m_dp[i];
      endcase
      clr = (wr && address == 2'd3) ? writedata : 32'd0;
      case (address)
        2'd0:    rdv = m_d[i];
        2'd2:    rdv = m_msk[i];
        2'd3:    rdv = m_ec[i];
        default: rdv = 32'd0;
      endcase
      m_ec[i] = ((m_ec[i] & ~clr) | ev) & wm;
      if (wr && address == 2'd2) m_msk[i] = writedata & wm;
      m_rd[i] = rdv;
      m_dp[i] = m_d[i];
      m_d[i]  = dn;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rd%0d", i), rd[i], m_rd[i]);
      check($sformatf("irq%0d", i), {31'd0, irq[i]},
            {31'd0, |(m_ec[i] & m_msk[i])});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int r;
    model_reset();
    for (int i = 0; i < N; i++) pin[i] = 32'hFFFF_FFFF;

    // reset with inputs high, then release
    repeat (3) cyc();
    check("rst_rd0", rd[0], 32'd0);
    reset_n = 1'b1;
    repeat (3) cyc();
    check("rel_rd0", rd[0], 32'h3FF);
    address = 2'd3;
    cyc();
    check("rel_ec0", rd[0], 32'h3FF);
    check("rel_irq0", {31'd0, irq[0]}, 32'd0);

    // rising edge on bit0 raises irq, W1C drops it
    pin[0] = 32'd0;
    repeat (4) cyc();
    wr(2'd2, 32'd1);
    wr(2'd3, 32'hFFFF_FFFF);
    pin[0] = 32'd1;
    cyc();
    cyc();
    check("t2_irq_early", {31'd0, irq[0]}, 32'd0);
    cyc();
    check("t2_irq", {31'd0, irq[0]}, 32'd1);
    wr(2'd3, 32'd1);
    check("t2_irq_clr", {31'd0, irq[0]}, 32'd0);
    cyc();
    check("t2_ec_clr", rd[0], 32'd0);

    // W1C in the same cycle as a new event: event wins
    pin[0] = 32'd0;
    repeat (4) cyc();
    pin[0] = 32'd1;
    cyc();
    cyc();
    wr(2'd3, 32'd1);
    check("t3_irq", {31'd0, irq[0]}, 32'd1);
    cyc();
    check("t3_ec", rd[0] & 32'd1, 32'd1);

    // debounce: short pulse ignored, held level accepted
    pin[1] = 32'd0;
    repeat (20) cyc();
    wr(2'd2, 32'h20);
    wr(2'd3, 32'hFFFF_FFFF);
    address = 2'd0;
    pin[1] = 32'h20;
    repeat (3) cyc();
    pin[1] = 32'd0;
    repeat (12) cyc();
    check("t4_glitch_d", rd[1], 32'd0);
    check("t4_glitch_irq", {31'd0, irq[1]}, 32'd0);
    pin[1] = 32'h20;
    repeat (11) cyc();
    check("t4_d5", (rd[1] >> 5) & 32'd1, 32'd1);
    repeat (9) cyc();
    address = 2'd3;
    cyc();
    check("t4_ec", rd[1], 32'h20);
    check("t4_irq", {31'd0, irq[1]}, 32'd1);

    // any-edge capture, masked, then unmasked
    wr(2'd2, 32'd0);
    pin[2] = 32'h8;
    repeat (6) cyc();
    wr(2'd3, 32'hFFFF_FFFF);
    pin[2] = 32'd0;
    repeat (6) cyc();
    pin[2] = 32'h8;
    repeat (6) cyc();
    address = 2'd3;
    cyc();
    check("t5_ec3", (rd[2] >> 3) & 32'd1, 32'd1);
    check("t5_irq_masked", {31'd0, irq[2]}, 32'd0);
    wr(2'd2, 32'h8);
    check("t5_irq_on", {31'd0, irq[2]}, 32'd1);

    // mask width and reserved address
    wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    cyc();
    check("t6_mask", rd[0], 32'h3FF);
    check("t6_mask4", rd[2], 32'hF);
    wr(2'd1, 32'hFFFF_FFFF);
    cyc();
    check("t6_rsvd", rd[0], 32'd0);

    // random traffic with one mid-run reset
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0)
          pin[i] = pin[i] ^ (32'd1 << $urandom_range(0, W[i] - 1));
      end
      r = $urandom_range(0, 9);
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (r < 2) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else if (r == 2) begin
        chipselect = 1'b0;
        write_n    = 1'b0;
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
      end
      if (c == 1200) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rnd_rst_rd0", rd[0], 32'd0);
        check("rnd_rst_irq0", {31'd0, irq[0]}, 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
